// File: rtl/sm_controller.sv
// ----------------------------------------------------------------------------
// sm_controller
//   Instruction register, decoder and sequencing FSM for the 16-bit
//   register/ALU/shifter datapath. One instruction is latched into IR while
//   idle, then the FSM walks one Moore state per cycle, driving the datapath
//   controls until the instruction completes and the controller is idle again.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   in        instruction word, captured into IR when load=1 in WAIT
//   load      IR capture strobe (ignored outside WAIT)
//   s         start execution of IR (sampled only in WAIT)
//   w         1 while idle in WAIT
//   readnum   register file read index
//   writenum  register file write index (always equal to readnum)
//   write     register file write enable
//   loada     A register load
//   loadb     B register load
//   loadc     C register load
//   loads     status register load
//   asel      1 = A operand forced to zero
//   bsel      1 = B operand is sximm5
//   vsel      writeback mux: 00 C, 01 PC, 10 sximm8, 11 mdata
//   ALUop     ALU operation (op field for ALU-class instructions, else 00)
//   shift     shifter control (sh field)
//   sximm5    IR[4:0] sign-extended
//   sximm8    IR[7:0] sign-extended
// ----------------------------------------------------------------------------
module sm_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WIMM,
        S_GETA,
        S_GETB,
        S_COMP,
        S_WREG
    } state_t;

    // One-hot register-field selects
    localparam logic [2:0] NSEL_RN = 3'b100;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b001;

    // Writeback mux encodings
    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b10;

    state_t      state;
    state_t      state_next;
    logic [15:0] ir;
    logic [2:0]  nsel;

    // IR field extraction
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
    logic [4:0] opk;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign opk    = {opcode, op};

    // Instruction classes that shape COMP
    logic is_cmp;
    logic a_zero;

    assign is_cmp = (opk == 5'b10101);
    // MOV Rd,Rm and MVN ignore the A operand; force it to zero
    assign a_zero = (opk == 5'b11000) || (opk == 5'b10111);

    // Immediates and shift come straight from IR at all times
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign shift  = sh;
    assign ALUop  = (opcode == 3'b101) ? op : 2'b00;

    // Register index mux driven by the registered one-hot select
    always_comb begin
        readnum = '0;
        if (nsel[2])
            readnum = rn;
        else if (nsel[1])
            readnum = rd;
        else if (nsel[0])
            readnum = rm;
    end

    assign writenum = readnum;

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_WAIT: begin
                if (s)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                case (opk)
                    5'b11010:                   state_next = S_WIMM;
                    5'b11000, 5'b10111:         state_next = S_GETB;
                    5'b10100, 5'b10101, 5'b10110: state_next = S_GETA;
                    default:                    state_next = S_WAIT;
                endcase
            end
            S_WIMM:  state_next = S_WAIT;
            S_GETA:  state_next = S_GETB;
            S_GETB:  state_next = S_COMP;
            S_COMP:  state_next = is_cmp ? S_WAIT : S_WREG;
            S_WREG:  state_next = S_WAIT;
            default: state_next = S_WAIT;
        endcase
    end

    // State, IR and registered Moore outputs. Outputs are computed from the
    // state being entered so they are valid for the whole cycle of that state.
    // IR cannot change on any edge that enters COMP, so COMP's IR-dependent
    // controls see the instruction being executed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
            ir    <= '0;
            w     <= 1'b1;
            nsel  <= '0;
            write <= 1'b0;
            loada <= 1'b0;
            loadb <= 1'b0;
            loadc <= 1'b0;
            loads <= 1'b0;
            asel  <= 1'b0;
            bsel  <= 1'b0;
            vsel  <= VSEL_C;
        end else begin
            state <= state_next;

            if (state == S_WAIT && load)
                ir <= in;

            w     <= 1'b0;
            nsel  <= '0;
            write <= 1'b0;
            loada <= 1'b0;
            loadb <= 1'b0;
            loadc <= 1'b0;
            loads <= 1'b0;
            asel  <= 1'b0;
            bsel  <= 1'b0;
            vsel  <= VSEL_C;

            case (state_next)
                S_WAIT: begin
                    w <= 1'b1;
                end
                S_WIMM: begin
                    nsel  <= NSEL_RN;
                    vsel  <= VSEL_IMM8;
                    write <= 1'b1;
                end
                S_GETA: begin
                    nsel  <= NSEL_RN;
                    loada <= 1'b1;
                end
                S_GETB: begin
                    nsel  <= NSEL_RM;
                    loadb <= 1'b1;
                end
                S_COMP: begin
                    asel  <= a_zero;
                    loadc <= ~is_cmp;
                    loads <= is_cmp;
                end
                S_WREG: begin
                    nsel  <= NSEL_RD;
                    vsel  <= VSEL_C;
                    write <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_controller.sv
// ----------------------------------------------------------------------------
// tb_sm_controller
//   Directed bench for sm_controller. Each instruction pushes the expected
//   per-cycle control snapshots onto a scoreboard queue; each cycle after the
//   clock edge one snapshot is popped and compared. A small behavioural
//   datapath driven by the DUT's controls checks end-to-end register results.
// ----------------------------------------------------------------------------
module tb_sm_controller;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  ALUop;
    logic [1:0]  shift;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    sm_controller dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .load     (load),
        .s        (s),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .ALUop    (ALUop),
        .shift    (shift),
        .sximm5   (sximm5),
        .sximm8   (sximm8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural datapath driven by the controller outputs
    // ------------------------------------------------------------------
    logic [15:0] rf [8] = '{default: 16'h0000};
    logic [15:0] ra = 16'h0000;
    logic [15:0] rb = 16'h0000;
    logic [15:0] rc = 16'h0000;
    logic        zflag = 1'b0;
    logic [15:0] bsh;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [15:0] alu;
    logic [15:0] wdata;

    always_comb begin
        case (shift)
            2'b00:   bsh = rb;
            2'b01:   bsh = {rb[14:0], 1'b0};
            2'b10:   bsh = {1'b0, rb[15:1]};
            default: bsh = {rb[15], rb[15:1]};
        endcase
        ain = asel ? 16'h0000 : ra;
        bin = bsel ? sximm5 : bsh;
        case (ALUop)
            2'b00:   alu = ain + bin;
            2'b01:   alu = ain - bin;
            2'b10:   alu = ain & bin;
            default: alu = ~bin;
        endcase
        case (vsel)
            2'b00:   wdata = rc;
            2'b10:   wdata = sximm8;
            default: wdata = 16'h0000;
        endcase
    end

    always @(posedge clk) begin
        if (write === 1'b1) rf[writenum] <= wdata;
        if (loada === 1'b1) ra <= rf[readnum];
        if (loadb === 1'b1) rb <= rf[readnum];
        if (loadc === 1'b1) rc <= alu;
        if (loads === 1'b1) zflag <= (alu == 16'h0000);
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        w;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic [1:0]  vsel;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic [1:0]  aluop;
        logic [1:0]  shift;
        logic [15:0] sximm8;
    } snap_t;

    localparam int ST_WAIT = 0;
    localparam int ST_DEC  = 1;
    localparam int ST_WIMM = 2;
    localparam int ST_GETA = 3;
    localparam int ST_GETB = 4;
    localparam int ST_COMP = 5;
    localparam int ST_WREG = 6;

    snap_t q[$];
    int    compared   = 0;
    int    mismatched = 0;

    function automatic snap_t snap(input int st, input logic [15:0] ir);
        snap_t e;
        logic [4:0] k;
        k = ir[15:11];
        e = '0;
        e.sximm8 = {{8{ir[7]}}, ir[7:0]};
        e.shift  = ir[4:3];
        e.aluop  = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
        case (st)
            ST_WAIT: e.w = 1'b1;
            ST_WIMM: begin
                e.readnum = ir[10:8]; e.vsel = 2'b10; e.write = 1'b1;
            end
            ST_GETA: begin
                e.readnum = ir[10:8]; e.loada = 1'b1;
            end
            ST_GETB: begin
                e.readnum = ir[2:0]; e.loadb = 1'b1;
            end
            ST_COMP: begin
                if (k == 5'b10101) e.loads = 1'b1;
                else               e.loadc = 1'b1;
                e.asel = (k == 5'b11000) || (k == 5'b10111);
            end
            ST_WREG: begin
                e.readnum = ir[7:5]; e.write = 1'b1;
            end
            default: ;
        endcase
        e.writenum = e.readnum;
        return e;
    endfunction

    function automatic snap_t observe();
        snap_t o;
        o.w = w; o.write = write; o.loada = loada; o.loadb = loadb;
        o.loadc = loadc; o.loads = loads; o.asel = asel; o.bsel = bsel;
        o.vsel = vsel; o.readnum = readnum; o.writenum = writenum;
        o.aluop = ALUop; o.shift = shift; o.sximm8 = sximm8;
        return o;
    endfunction

    // Expected state walk for one instruction, from DECODE back to WAIT
    task automatic push_seq(input logic [15:0] ir);
        logic [4:0] k;
        k = ir[15:11];
        q.push_back(snap(ST_DEC, ir));
        if (k == 5'b11010) begin
            q.push_back(snap(ST_WIMM, ir));
        end else if (k == 5'b11000 || k == 5'b10111) begin
            q.push_back(snap(ST_GETB, ir));
            q.push_back(snap(ST_COMP, ir));
            q.push_back(snap(ST_WREG, ir));
        end else if (k == 5'b10100 || k == 5'b10101 || k == 5'b10110) begin
            q.push_back(snap(ST_GETA, ir));
            q.push_back(snap(ST_GETB, ir));
            q.push_back(snap(ST_COMP, ir));
            if (k != 5'b10101) q.push_back(snap(ST_WREG, ir));
        end
        q.push_back(snap(ST_WAIT, ir));
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load (separately or together with s), execute and score one instruction.
    // glitch_idx: step after which load=1/in=0xD0FF is driven for one edge.
    // reset_idx:  step after which reset is asserted mid-cycle.
    task automatic exec(input logic [15:0] word, input bit together,
                        input int glitch_idx, input int reset_idx,
                        input string name);
        snap_t e;
        int n;
        if (!together) begin
            in = word; load = 1'b1; s = 1'b0;
            tick();
            load = 1'b0;
            chk({name, " loaded"}, 64'(observe()), 64'(snap(ST_WAIT, word)));
        end
        in = word; load = together; s = 1'b1;
        push_seq(word);
        n = q.size();
        for (int k = 0; k < n; k++) begin
            tick();
            s = 1'b0; load = 1'b0; in = 16'($urandom);
            e = q.pop_front();
            chk($sformatf("%s step%0d", name, k), 64'(observe()), 64'(e));
            if (k == glitch_idx) begin
                in = 16'hD0FF; load = 1'b1;
            end
            if (k == reset_idx) begin
                #2 reset = 1'b1;
                #1;
                chk({name, " async reset w/loadc"}, 64'({w, loadc, write}), 64'(3'b100));
                tick();
                reset = 1'b0;
                q.delete();
                chk({name, " after reset"}, 64'(observe()), 64'(snap(ST_WAIT, 16'h0000)));
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        in    = 16'($urandom);
        load  = 1'b1;
        s     = 1'b0;
        tick();
        tick();
        chk("reset state", 64'(observe()), 64'(snap(ST_WAIT, 16'h0000)));
        chk("reset sximm5", 64'(sximm5), 64'(16'h0000));
        reset = 1'b0;
        load  = 1'b0;

        exec(16'hD007, 1'b0, -1, -1, "mov_r0_7");
        chk("R0 after mov imm", 64'(rf[0]), 64'(16'h0007));

        exec(16'hD1FE, 1'b0, -1, -1, "mov_r1_m2");
        chk("R1 after mov imm", 64'(rf[1]), 64'(16'hFFFE));
        chk("sximm5 of 0xD1FE", 64'(sximm5), 64'(16'hFFFE));

        exec(16'hA148, 1'b0, -1, -1, "add_r2");
        chk("R2 after add", 64'(rf[2]), 64'(16'h000C));
        chk("sximm5 of 0xA148", 64'(sximm5), 64'(16'h0008));

        exec(16'hA801, 1'b0, -1, -1, "cmp_r0_r1");
        chk("Z after cmp 7,-2", 64'(zflag), 64'(1'b0));
        chk("C untouched by cmp", 64'(rc), 64'(16'h000C));

        exec(16'hB860, 1'b0, -1, -1, "mvn_r3");
        chk("R3 after mvn", 64'(rf[3]), 64'(16'hFFF8));

        exec(16'hE000, 1'b0, -1, -1, "unknown");

        exec(16'hC0A8, 1'b1, -1, -1, "mov_r5_r0_lsl");
        chk("R5 after mov reg", 64'(rf[5]), 64'(16'h000E));

        // Load during GETB must not disturb the running ADD
        exec(16'hA148, 1'b0, 2, -1, "add_glitch");
        chk("R2 after add with ignored load", 64'(rf[2]), 64'(16'h000C));

        // Reset in COMP of ADD R4,R1,R0,LSL#1: no writeback follows
        exec(16'hA188, 1'b0, -1, 3, "add_reset");
        tick();
        tick();
        chk("R4 not written after reset", 64'(rf[4]), 64'(16'h0000));
        chk("idle after reset", 64'(observe()), 64'(snap(ST_WAIT, 16'h0000)));

        // s held high: back-to-back MOV imm, w high for exactly one cycle
        in = 16'hD007; load = 1'b1; s = 1'b1;
        push_seq(16'hD007);
        push_seq(16'hD007);
        for (int k = 0; k < 6; k++) begin
            snap_t e;
            tick();
            load = 1'b0;
            if (k >= 3) s = 1'b0;
            e = q.pop_front();
            chk($sformatf("b2b step%0d", k), 64'(observe()), 64'(e));
        end
        chk("scoreboard drained", 64'(q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
